// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the round-robin system bus arbiter.
package bus_arbiter_pkg;

    localparam int          BUS_W     = 32;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
    localparam logic        R_W_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping at N-1 -> 0.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          valid
);

    logic [IW:0] slot;

    always_comb begin
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        slot   = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single subtraction wraps the candidate
            slot = {1'b0, ptr} + (IW+1)'(k);
            if (slot >= (IW+1)'(N)) slot = slot - (IW+1)'(N);
            if (!valid && req[slot[IW-1:0]]) begin
                valid = 1'b1;
                index = slot[IW-1:0];
            end
        end
        if (valid) onehot[index] = 1'b1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared 32-bit system bus: IDLE -> BUSY -> DONE.
// Optional watchdog abort when compiled with BUS_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_MASTERS-1:0]   m_req,
    input  logic [N_MASTERS-1:0]   m_r_w,
    input  logic [32*N_MASTERS-1:0] m_addr,
    input  logic [32*N_MASTERS-1:0] m_wdata,
    output logic [BUS_W-1:0]       m_rdata,
    output logic [N_MASTERS-1:0]   m_ready,
    output logic [N_MASTERS-1:0]   m_err,
    output logic [N_MASTERS-1:0]   grant,
    output logic [BUS_W-1:0]       bus_addr,
    output logic                   bus_r_w,
    output logic                   bus_request,
    inout  wire  [BUS_W-1:0]       bus_data,
    input  logic                   bus_ready
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [N_MASTERS-1:0] ready_q, ready_d;
    logic [N_MASTERS-1:0] err_q, err_d;
    logic                 req_q, req_d;
    logic [BUS_W-1:0]     rdata_q, rdata_d;

    logic [N_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;

    logic                 busy;
    logic                 owner_rw;
    logic [BUS_W-1:0]     owner_addr;
    logic [BUS_W-1:0]     owner_wdata;

`ifdef BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
        .req    (m_req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .valid  (pick_valid)
    );

    assign busy        = (state_q == BUSY);
    assign owner_rw    = m_r_w[owner_q];
    assign owner_addr  = m_addr[32*owner_q +: 32];
    assign owner_wdata = m_wdata[32*owner_q +: 32];

    assign bus_addr    = busy ? owner_addr : '0;
    assign bus_r_w     = busy ? owner_rw : 1'b0;
    assign bus_data    = (busy && owner_rw == R_W_WRITE) ? owner_wdata : 'z;

    assign grant       = grant_q;
    assign bus_request = req_q;
    assign m_ready     = ready_q;
    assign m_err       = err_q;
    assign m_rdata     = rdata_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        req_d   = req_q;
        ready_d = '0;
        err_d   = '0;
        rdata_d = rdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    req_d   = 1'b1;
                    ptr_d   = (pick_idx == IW'(N_MASTERS-1)) ? '0 : pick_idx + 1'b1;
`ifdef BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                // ready on the expiry cycle takes precedence over the watchdog
                if (bus_ready) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    ready_d = grant_q;
                    if (owner_rw != R_W_WRITE) rdata_d = bus_data;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT-1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    ready_d = grant_q;
                    err_d   = grant_q;
                    rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            req_q   <= 1'b0;
            ready_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: four masters, a 1-cycle slave on 0..0x1FFF, silent elsewhere.
module tb_bus_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_r_w = '0;
    logic [32*N-1:0] m_addr = '0;
    logic [32*N-1:0] m_wdata = '0;
    logic [31:0]     m_rdata;
    logic [N-1:0]    m_ready, m_err, grant;
    logic [31:0]     bus_addr;
    logic            bus_r_w, bus_request;
    wire  [31:0]     bus_data;
    logic            bus_ready;

    logic            slv_ready = 1'b0;
    logic            ready_force = 1'b0;
    logic            mem_init = 1'b0;
    logic [31:0]     mem [0:8191];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;

    typedef struct {
        int          m;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    bus_arbiter #(.N_MASTERS(N), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req       (m_req),
        .m_r_w       (m_r_w),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .m_err       (m_err),
        .grant       (grant),
        .bus_addr    (bus_addr),
        .bus_r_w     (bus_r_w),
        .bus_request (bus_request),
        .bus_data    (bus_data),
        .bus_ready   (bus_ready)
    );

    // Dummy slave: answers one cycle after seeing request, only inside its window
    assign bus_ready = slv_ready | ready_force;
    assign bus_data  = (slv_ready && bus_request && !bus_r_w) ? mem[bus_addr[12:0]] : 32'bz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        slv_ready <= bus_request && !slv_ready && (bus_addr < 32'h2000);
        if (!mem_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 32'hA5A5_0000 | i;
            mem[16] <= 32'h1234_5678;
            mem_init <= 1'b1;
        end else if (slv_ready && bus_request && bus_r_w) begin
            mem[bus_addr[12:0]] <= bus_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_master(input int m, input logic rw, input logic [31:0] addr,
                              input logic [31:0] wdata);
        m_r_w[m]           = rw;
        m_addr[32*m +: 32]  = addr;
        m_wdata[32*m +: 32] = wdata;
        m_req[m]           = 1'b1;
    endtask

    task automatic wait_ready(input int m, input string name, output int n);
        n = 0;
        while (!m_ready[m] && n < 40) begin
            tick();
            n++;
        end
        if (!m_ready[m]) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for m_ready[%0d]", name, m);
        end
    endtask

    task automatic do_xfer(input vec_t v, input string name);
        int n;
        logic [N-1:0] oh;
        oh = N'(1) << v.m;
        set_master(v.m, v.rw, v.addr, v.wdata);
        tick();
        chk({name, " grant busy"}, 32'(grant), 32'(oh));
        chk({name, " bus_request"}, 32'(bus_request), 32'd1);
        chk({name, " bus_addr"}, bus_addr, v.addr);
        chk({name, " bus_r_w"}, 32'(bus_r_w), 32'(v.rw));
        if (v.rw) chk({name, " bus_data drive"}, bus_data, v.wdata);
        wait_ready(v.m, name, n);
        chk({name, " latency"}, 32'(n + 1), 32'd3);
        chk({name, " m_ready"}, 32'(m_ready), 32'(oh));
        chk({name, " m_err"}, 32'(m_err), 32'd0);
        chk({name, " grant done"}, 32'(grant), 32'(oh));
        chk({name, " req drop"}, 32'(bus_request), 32'd0);
        chk({name, " m_rdata"}, m_rdata, v.exp_rdata);
        m_req[v.m] = 1'b0;
        tick();
        chk({name, " strobe 1cyc"}, 32'(m_ready), 32'd0);
        chk({name, " grant idle"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int n;
        int last;
        logic [31:0] held;

        tbl[0] = '{m: 0, rw: 1'b0, addr: 32'h10,   wdata: 32'h0,         exp_rdata: 32'h1234_5678};
        tbl[1] = '{m: 1, rw: 1'b1, addr: 32'h20,   wdata: 32'hCAFE_F00D, exp_rdata: 32'h1234_5678};
        tbl[2] = '{m: 1, rw: 1'b0, addr: 32'h20,   wdata: 32'h0,         exp_rdata: 32'hCAFE_F00D};
        tbl[3] = '{m: 3, rw: 1'b1, addr: 32'h1FFF, wdata: 32'h0BAD_F00D, exp_rdata: 32'hCAFE_F00D};
        tbl[4] = '{m: 2, rw: 1'b0, addr: 32'h1FFF, wdata: 32'h0,         exp_rdata: 32'h0BAD_F00D};
        tbl[5] = '{m: 0, rw: 1'b0, addr: 32'h100,  wdata: 32'h0,         exp_rdata: 32'hA5A5_0100};

        // reset state
        tick();
        tick();
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst bus_request", 32'(bus_request), 32'd0);
        chk("rst m_ready", 32'(m_ready), 32'd0);
        chk("rst m_err", 32'(m_err), 32'd0);
        chk("rst m_rdata", m_rdata, 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst bus_r_w", 32'(bus_r_w), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) do_xfer(tbl[i], $sformatf("vec%0d", i));

        // all four request together from reset; held requests keep rotating 0,1,2,3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_master(i, 1'b0, 32'h40 + 32'(i), 32'h0);
        last = cyc;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (m_ready == '0 && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("rr order %0d", k), 32'(m_ready), 32'(N'(1) << (k % N)));
            chk($sformatf("rr rdata %0d", k), m_rdata, 32'hA5A5_0040 + 32'(k % N));
            chk($sformatf("rr spacing %0d", k), 32'(cyc - last), (k == 0) ? 32'd3 : 32'd4);
            last = cyc;
            if (k == 7) m_req = '0;
            tick();
            chk($sformatf("rr no overlap %0d", k), 32'(m_ready), 32'd0);
        end
        tick();

        // reset in the middle of BUSY aborts silently and clears the rr pointer
        set_master(0, 1'b0, 32'h10, 32'h0);
        tick();
        chk("abort busy grant", 32'(grant), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort grant", 32'(grant), 32'd0);
        chk("abort bus_request", 32'(bus_request), 32'd0);
        chk("abort m_ready", 32'(m_ready), 32'd0);
        rst_n = 1'b1;
        m_req = '0;
        tick();
        chk("abort idle m_ready", 32'(m_ready), 32'd0);
        chk("abort idle grant", 32'(grant), 32'd0);
        set_master(0, 1'b0, 32'h10, 32'h0);
        set_master(1, 1'b0, 32'h11, 32'h0);
        tick();
        chk("ptr reset grant", 32'(grant), 32'd1);
        wait_ready(0, "ptr reset m0", n);
        m_req[0] = 1'b0;
        wait_ready(1, "ptr reset m1", n);
        chk("ptr reset m1 rdata", m_rdata, 32'hA5A5_0011);
        m_req[1] = 1'b0;
        tick();
        tick();

        // read of an address nobody answers
        set_master(2, 1'b0, 32'h4000, 32'h0);
        tick();
        chk("silent grant", 32'(grant), 32'h4);
`ifdef BUS_TIMEOUT_EN
        wait_ready(2, "timeout", n);
        chk("timeout latency", 32'(n + 1), 32'd17);
        chk("timeout m_ready", 32'(m_ready), 32'h4);
        chk("timeout m_err", 32'(m_err), 32'h4);
        chk("timeout m_rdata", m_rdata, 32'hDEAD_BEEF);
        m_req[2] = 1'b0;
        tick();
        chk("timeout err 1cyc", 32'(m_err), 32'd0);
        tick();
`else
        repeat (20) tick();
        chk("hang bus_request", 32'(bus_request), 32'd1);
        chk("hang m_ready", 32'(m_ready), 32'd0);
        chk("hang m_err", 32'(m_err), 32'd0);
        chk("hang grant", 32'(grant), 32'h4);
        rst_n = 1'b0;
        m_req = '0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        // bus_ready held high outside BUSY does nothing
        held = m_rdata;
        ready_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("idle rdy grant %0d", i), 32'(grant), 32'd0);
            chk($sformatf("idle rdy m_ready %0d", i), 32'(m_ready), 32'd0);
            chk($sformatf("idle rdy req %0d", i), 32'(bus_request), 32'd0);
        end
        chk("idle rdy m_rdata", m_rdata, held);
        ready_force = 1'b0;
        set_master(3, 1'b0, 32'h30, 32'h0);
        wait_ready(3, "done rdy", n);
        ready_force = 1'b1;
        m_req[3] = 1'b0;
        tick();
        chk("done rdy m_ready", 32'(m_ready), 32'd0);
        chk("done rdy grant", 32'(grant), 32'd0);
        chk("done rdy rdata", m_rdata, 32'hA5A5_0030);
        tick();
        chk("done rdy idle grant", 32'(grant), 32'd0);
        chk("done rdy idle req", 32'(bus_request), 32'd0);
        ready_force = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
